// File: rtl/vending_machine.sv
// vending_machine: 3-rupee single-product controller accepting 1/2 rupee coins,
// with registered dispense pulse and change/refund output.
module vending_machine (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic       out,
    output logic [1:0] change
);
    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2} state_t;

    state_t     r_state;
    logic       r_out;
    logic [1:0] r_change;

    assign out    = r_out;
    assign change = r_change;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S0;
            r_out    <= 1'b0;
            r_change <= 2'd0;
        end else begin
            r_out    <= 1'b0;
            r_change <= 2'd0;
            case (r_state)
                S0: r_state <= (in == 2'b01) ? S1 : (in == 2'b10) ? S2 : S0;
                S1: begin
                    r_state  <= (in == 2'b00) ? S1 : (in == 2'b01) ? S2 : S0;
                    r_out    <= (in == 2'b10);
                    r_change <= (in == 2'b11) ? 2'd1 : 2'd0;
                end
                S2: begin
                    r_state  <= (in == 2'b00) ? S2 : S0;
                    r_out    <= (in == 2'b01) || (in == 2'b10);
                    r_change <= (in == 2'b10) ? 2'd1 : (in == 2'b11) ? 2'd2 : 2'd0;
                end
                // unused encoding recovers to idle with quiet outputs
                default: r_state <= S0;
            endcase
        end
    end
endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: directed self-checking bench for vending_machine.
module tb_vending_machine;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] in  = 2'b01;
    logic       out;
    logic [1:0] change;
    int         checks   = 0;
    int         failures = 0;

    vending_machine dut (.clk(clk), .rst(rst), .in(in), .out(out), .change(change));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic eo, input logic [1:0] ec);
        checks++;
        assert (out === eo) else begin
            failures++;
            $error("FAIL %s out: got %b want %b", tag, out, eo);
        end
        checks++;
        assert (change === ec) else begin
            failures++;
            $error("FAIL %s change: got %b want %b", tag, change, ec);
        end
    endtask

    // drive a code before the edge, check outputs just after it
    task automatic coin(input string tag, input logic [1:0] c, input logic eo, input logic [1:0] ec);
        @(negedge clk);
        in = c;
        @(posedge clk);
        #1;
        check(tag, eo, ec);
    endtask

    // pull reset low mid-cycle, check outputs clear without an edge, release at negedge
    task automatic async_reset(input string tag);
        #2;
        in  = 2'b00;
        rst = 1'b0;
        #1;
        check(tag, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 1'b0, 2'd0);
        @(negedge clk);
        in  = 2'b00;
        rst = 1'b1;
        coin("rst_noadv_a", 2'b10, 1'b0, 2'd0);
        coin("rst_noadv_b", 2'b01, 1'b1, 2'd0);
        coin("idle", 2'b00, 1'b0, 2'd0);

        coin("exact111_a", 2'b01, 1'b0, 2'd0);
        coin("exact111_b", 2'b00, 1'b0, 2'd0);
        coin("exact111_c", 2'b01, 1'b0, 2'd0);
        coin("exact111_d", 2'b00, 1'b0, 2'd0);
        coin("exact111_e", 2'b01, 1'b1, 2'd0);
        coin("exact111_f", 2'b00, 1'b0, 2'd0);

        coin("over112_a", 2'b01, 1'b0, 2'd0);
        coin("over112_b", 2'b01, 1'b0, 2'd0);
        coin("over112_c", 2'b10, 1'b1, 2'd1);
        coin("over112_d", 2'b00, 1'b0, 2'd0);

        coin("pay21_a", 2'b10, 1'b0, 2'd0);
        coin("pay21_b", 2'b01, 1'b1, 2'd0);
        coin("pay12_a", 2'b01, 1'b0, 2'd0);
        coin("pay12_b", 2'b10, 1'b1, 2'd0);
        coin("pay22_a", 2'b10, 1'b0, 2'd0);
        coin("pay22_b", 2'b10, 1'b1, 2'd1);
        async_reset("async_clr_out");

        coin("b2b_a", 2'b10, 1'b0, 2'd0);
        coin("b2b_b", 2'b01, 1'b1, 2'd0);
        coin("b2b_c", 2'b10, 1'b0, 2'd0);
        coin("cancel2", 2'b11, 1'b0, 2'd2);
        coin("cancel2_clr", 2'b00, 1'b0, 2'd0);
        coin("cancel1_a", 2'b01, 1'b0, 2'd0);
        coin("cancel1", 2'b11, 1'b0, 2'd1);
        coin("cancel0", 2'b11, 1'b0, 2'd0);
        coin("idle2", 2'b00, 1'b0, 2'd0);

        coin("cont1", 2'b01, 1'b0, 2'd0);
        coin("cont2", 2'b01, 1'b0, 2'd0);
        coin("cont3", 2'b01, 1'b1, 2'd0);
        coin("cont4", 2'b01, 1'b0, 2'd0);
        coin("cont5", 2'b01, 1'b0, 2'd0);
        coin("cont6", 2'b01, 1'b1, 2'd0);
        coin("cont_end", 2'b00, 1'b0, 2'd0);

        coin("s2_before_rst", 2'b10, 1'b0, 2'd0);
        async_reset("async_in_s2");
        coin("post_rst_s1", 2'b01, 1'b0, 2'd0);
        coin("post_rst_s2", 2'b01, 1'b0, 2'd0);
        coin("post_rst_buy", 2'b01, 1'b1, 2'd0);
        coin("final_idle", 2'b00, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vending_machine.md
Name: vending_machine

Overview:
- Single-product coin-accepting vending controller.
- Coins are 1 rupee and 2 rupees; the product price is 3 rupees.
- Tracks the accumulated credit in a small FSM, dispenses when credit reaches at least 3, returns 1 rupee change on overpay, and supports a cancel/refund code.
- Sits between a coin-acceptor front end (one coin code per clock) and the dispense/change actuators.

Parameters:
- None. Price is fixed at 3 rupees; coin values are fixed at 1 and 2.

Ports:
- clk  input  1  rising-edge system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in  input  2  coin code, sampled every rising edge: 00 none, 01 one rupee, 10 two rupees, 11 cancel/refund.
- out  output  1  dispense pulse, registered.
- change  output  2  change/refund amount in rupees (0..2), registered.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (rst).
- States (credit held): S0 = 0, S1 = 1, S2 = 2. Encoding is free; use 2 bits.
- Reset (rst=0, asynchronous): state goes to S0, out=0, change=00 immediately, without waiting for a clock edge.
- Reset is honoured mid-transaction: any accumulated credit is discarded, with no refund pulse.
- Reset release is synchronised in the usual way; the first edge after release evaluates normally.
- Every rising edge with rst=1 evaluates `in` as exactly one event.
  - A code held for N cycles counts as N coins.
  - The upstream block must drive 00 between coins.
- Outputs are registered.
  - They reflect the transaction completed at the current edge.
  - They are valid for exactly that one cycle.
  - They return to 0/00 on the next edge unless a new transaction completes.
- Transition table (next state / out / change):
  - S0, 00 -> S0 / 0 / 00
  - S0, 01 -> S1 / 0 / 00
  - S0, 10 -> S2 / 0 / 00
  - S0, 11 -> S0 / 0 / 00 (nothing to refund)
  - S1, 00 -> S1 / 0 / 00
  - S1, 01 -> S2 / 0 / 00
  - S1, 10 -> S0 / 1 / 00 (exact 3)
  - S1, 11 -> S0 / 0 / 01 (refund 1)
  - S2, 00 -> S2 / 0 / 00
  - S2, 01 -> S0 / 1 / 00 (exact 3)
  - S2, 10 -> S0 / 1 / 01 (4 paid, 1 back)
  - S2, 11 -> S0 / 0 / 10 (refund 2)
- out and a nonzero change may be asserted together only in the overpay case; cancel never asserts out.
- Back-to-back purchases are allowed with no idle cycle.
  - Example: S2 +01 dispenses, then a 10 on the next edge moves S0 -> S2.
- No illegal state is reachable.
  - If the unused state encoding is ever entered, the next edge goes to S0 with out=0, change=00.
- Latency: coin accepted at edge k -> out/change visible after edge k, cleared after edge k+1.
- No combinational path from in to out/change.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in=01 -> out=0, change=00, no state advance. Assert rst=0 asynchronously mid-cycle while in S2 -> outputs 0/00 at once; after release, a 01 moves to S1 with no dispense.
- Exact pay 1+1+1 (one code per cycle, 00 between) -> out=1, change=00 for one cycle after the third coin; state S0.
- Overpay: 1, 1, 2 on consecutive edges (in held at 01 for two cycles, then 10) -> after the 10 edge, out=1, change=01 for one cycle; then 0/00 with in=00.
- Orders 2+1 and 1+2 -> each gives out=1, change=00. Order 2+2 -> out=1, change=01.
- Cancel: 2 then 11 -> out=0, change=10 one cycle. 1 then 11 -> change=01. 11 from S0 -> change=00.
- Continuous in=01 for 6 cycles -> out pulses on cycles 3 and 6 only; change stays 00 throughout.
